// File: rtl/filtro_extremo_ventana_if.sv
// Sample stream bundle for the sliding-window extremum filter.
// The master drives samples in and reads results; the filter itself is the slave.
interface filtro_extremo_ventana_if #(
   parameter int ANCHO = 8
);
   logic [ANCHO-1:0] dato_entrada;
   logic             entrada_valida;
   logic             inicio_linea;
   logic             modo_min;
   logic [ANCHO-1:0] dato_salida;
   logic             salida_valida;

   modport master (
      output dato_entrada,
      output entrada_valida,
      output inicio_linea,
      output modo_min,
      input  dato_salida,
      input  salida_valida
   );

   modport slave (
      input  dato_entrada,
      input  entrada_valida,
      input  inicio_linea,
      input  modo_min,
      output dato_salida,
      output salida_valida
   );
endinterface

// File: rtl/filtro_extremo_ventana.sv
// Streaming sliding-window max/min filter: VENTANA-sample shift register feeding
// a registered pairwise reduction tree, with mode and valid carried alongside the data.
module filtro_extremo_ventana #(
   parameter int ANCHO   = 8,
   parameter int VENTANA = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   filtro_extremo_ventana_if.slave bus
);
   localparam int NIVELES   = $clog2(VENTANA);
   localparam int ANCHO_CNT = $clog2(VENTANA + 1);
   localparam int RANURAS   = 2 * VENTANA;

   // Level 0 is the window itself; level l holds ceil(VENTANA / 2^l) live entries.
   logic [ANCHO-1:0]     nodo_p [0:NIVELES][0:RANURAS-1];
   logic                 modo_p [0:NIVELES];
   logic                 vld_p  [0:NIVELES];
   logic [ANCHO_CNT-1:0] cuenta;
   logic [ANCHO_CNT-1:0] cuenta_sig;
   logic                 resultado;
   logic [ANCHO-1:0]     dato_q;
   logic                 valida_q;

   function automatic logic [ANCHO-1:0] extremo(input logic [ANCHO-1:0] a,
                                               input logic [ANCHO-1:0] b,
                                               input logic             es_min);
      if (es_min) return (a < b) ? a : b;
      return (a > b) ? a : b;
   endfunction

   function automatic int entradas(input int nivel);
      return (VENTANA + (1 << nivel) - 1) >> nivel;
   endfunction

   // Window contents are not cleared on a line start: the fill count alone keeps
   // stale samples out, since they are shifted out before the next result is due.
   always_comb begin
      cuenta_sig = cuenta;
      resultado  = 1'b0;
      if (bus.entrada_valida) begin
         if (bus.inicio_linea)
            cuenta_sig = ANCHO_CNT'(1);
         else if (cuenta != ANCHO_CNT'(VENTANA))
            cuenta_sig = cuenta + ANCHO_CNT'(1);
         resultado = (cuenta_sig == ANCHO_CNT'(VENTANA));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cuenta   <= '0;
         dato_q   <= '0;
         valida_q <= 1'b0;
         for (int l = 0; l <= NIVELES; l++) begin
            modo_p[l] <= 1'b0;
            vld_p[l]  <= 1'b0;
            for (int i = 0; i < RANURAS; i++) nodo_p[l][i] <= '0;
         end
      end else begin
         // stage p0: window shift, mode capture, result qualification
         cuenta   <= cuenta_sig;
         vld_p[0] <= resultado;
         if (bus.entrada_valida) begin
            modo_p[0]    <= bus.modo_min;
            nodo_p[0][0] <= bus.dato_entrada;
            for (int i = 1; i < VENTANA; i++) nodo_p[0][i] <= nodo_p[0][i-1];
         end
         // stages p1..pNIVELES: pairwise reduction, odd leftover passes through
         for (int l = 1; l <= NIVELES; l++) begin
            vld_p[l]  <= vld_p[l-1];
            modo_p[l] <= modo_p[l-1];
            for (int i = 0; i < RANURAS; i++) begin
               if (i < entradas(l)) begin
                  if (2 * i + 1 < entradas(l - 1))
                     nodo_p[l][i] <= extremo(nodo_p[l-1][2*i], nodo_p[l-1][2*i+1], modo_p[l-1]);
                  else
                     nodo_p[l][i] <= nodo_p[l-1][2*i];
               end else begin
                  nodo_p[l][i] <= '0;
               end
            end
         end
         // output stage: strobe each result, hold data between results
         valida_q <= vld_p[NIVELES];
         if (vld_p[NIVELES]) dato_q <= nodo_p[NIVELES][0];
      end
   end

   assign bus.dato_salida   = dato_q;
   assign bus.salida_valida = valida_q;
endmodule

// File: tb/tb_filtro_extremo_ventana.sv
// Bench for the window extremum filter: VENTANA=5 and VENTANA=1 instances share one
// stimulus stream and are scored every cycle against a queue-based window model.
module tb_filtro_extremo_ventana;
   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   filtro_extremo_ventana_if #(.ANCHO(8)) bus5 ();
   filtro_extremo_ventana_if #(.ANCHO(8)) bus1 ();

   filtro_extremo_ventana #(.ANCHO(8), .VENTANA(5)) dut5 (.clk(clk), .reset(reset), .bus(bus5));
   filtro_extremo_ventana #(.ANCHO(8), .VENTANA(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

   typedef struct packed {
      logic       vld;
      logic [7:0] dato;
      logic       clr;
   } ent_t;

   ent_t       cola [2][$];
   logic [7:0] hist [2][$];
   logic [7:0] ult  [2];
   int n_chk = 0;
   int n_err = 0;
   int n_str = 0;
   int n_paso = 0;

   function automatic int ventana(input int d);
      return (d == 0) ? 5 : 1;
   endfunction

   // results appear 1 + clog2(VENTANA) edges after the accepting edge
   function automatic int lat(input int d);
      return (d == 0) ? 4 : 1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic paso(input logic r, input logic v, input logic ini, input logic mm,
                       input logic [7:0] x);
      ent_t       e;
      logic [7:0] ext;
      logic       ov;
      logic [7:0] od;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         e = cola[d].pop_front();
         if (e.clr) ult[d] = 8'd0;
         else if (e.vld) ult[d] = e.dato;
         ov = (d == 0) ? bus5.salida_valida : bus1.salida_valida;
         od = (d == 0) ? bus5.dato_salida : bus1.dato_salida;
         chk($sformatf("valida v%0d paso %0d", ventana(d), n_paso), 32'(ov), 32'(e.vld));
         chk($sformatf("dato v%0d paso %0d", ventana(d), n_paso), 32'(od), 32'(ult[d]));
      end
      if (bus5.salida_valida === 1'b1) n_str++;
      reset = r;
      bus5.entrada_valida = v;  bus1.entrada_valida = v;
      bus5.inicio_linea   = ini; bus1.inicio_linea  = ini;
      bus5.modo_min       = mm; bus1.modo_min       = mm;
      bus5.dato_entrada   = x;  bus1.dato_entrada   = x;
      for (int d = 0; d < 2; d++) begin
         e = '0;
         if (r) begin
            hist[d].delete();
            cola[d].delete();
            e.clr = 1'b1;
            for (int k = 0; k <= lat(d); k++) cola[d].push_back(e);
         end else begin
            if (v) begin
               if (ini) hist[d].delete();
               hist[d].push_front(x);
               if (hist[d].size() > ventana(d)) void'(hist[d].pop_back());
               if (hist[d].size() == ventana(d)) begin
                  ext = hist[d][0];
                  foreach (hist[d][k]) begin
                     if (mm) ext = (hist[d][k] < ext) ? hist[d][k] : ext;
                     else    ext = (hist[d][k] > ext) ? hist[d][k] : ext;
                  end
                  e.vld  = 1'b1;
                  e.dato = ext;
               end
            end
            cola[d].push_back(e);
         end
      end
      n_paso++;
   endtask

   task automatic muestra(input logic ini, input logic mm, input logic [7:0] x);
      paso(1'b0, 1'b1, ini, mm, x);
   endtask

   task automatic ocioso(input int n);
      for (int k = 0; k < n; k++) paso(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
   endtask

   logic [7:0] base [7];
   ent_t       vacio;

   initial begin
      base = '{8'd10, 8'd50, 8'd30, 8'd20, 8'd40, 8'd5, 8'd1};
      reset = 1'b1;
      bus5.entrada_valida = 1'b0; bus1.entrada_valida = 1'b0;
      bus5.inicio_linea   = 1'b0; bus1.inicio_linea   = 1'b0;
      bus5.modo_min       = 1'b0; bus1.modo_min       = 1'b0;
      bus5.dato_entrada   = 8'd0; bus1.dato_entrada   = 8'd0;
      ult[0] = 8'd0;
      ult[1] = 8'd0;
      repeat (2) @(posedge clk);
      vacio = '0;
      vacio.clr = 1'b1;
      for (int d = 0; d < 2; d++)
         for (int k = 0; k <= lat(d); k++) cola[d].push_back(vacio);

      // basic max: results 50, 50, 40
      n_str = 0;
      for (int i = 0; i < 7; i++) muestra(1'b0, 1'b0, base[i]);
      ocioso(6);
      chk("strobes basico", 32'(n_str), 32'd3);

      // min then mode switch: 10, then 60
      n_str = 0;
      for (int i = 0; i < 5; i++) muestra(i == 0, 1'b1, base[i]);
      muestra(1'b0, 1'b0, 8'd60);
      ocioso(6);
      chk("strobes modo", 32'(n_str), 32'd2);

      // three idle cycles between every sample
      n_str = 0;
      for (int i = 0; i < 7; i++) begin
         muestra(i == 0, 1'b0, base[i]);
         ocioso(3);
      end
      ocioso(6);
      chk("strobes huecos", 32'(n_str), 32'd3);

      // line flush after 7 samples: only the trailing 3 produces 200
      n_str = 0;
      for (int i = 0; i < 7; i++) muestra(i == 0, 1'b0, 8'(9 - i));
      muestra(1'b1, 1'b0, 8'd0);
      muestra(1'b0, 1'b0, 8'd200);
      muestra(1'b0, 1'b0, 8'd1);
      muestra(1'b0, 1'b0, 8'd2);
      muestra(1'b0, 1'b0, 8'd3);
      ocioso(6);
      chk("strobes linea", 32'(n_str), 32'd4);

      // reset with three results in flight, then a refill too short to emit
      n_str = 0;
      for (int i = 0; i < 7; i++) muestra(i == 0, 1'b0, 8'(100 + i));
      paso(1'b1, 1'b1, 1'b0, 1'b0, 8'd99);
      for (int i = 0; i < 4; i++) muestra(1'b0, 1'b0, 8'(150 + i));
      ocioso(6);
      chk("strobes reset", 32'(n_str), 32'd0);

      // extreme windows
      n_str = 0;
      for (int i = 0; i < 5; i++) muestra(i == 0, 1'b0, 8'd255);
      for (int i = 0; i < 5; i++) muestra(i == 0, 1'b1, 8'd0);
      for (int i = 0; i < 5; i++) muestra(i == 0, 1'b0, 8'd0);
      ocioso(6);
      chk("strobes extremos", 32'(n_str), 32'd3);

      // randomized traffic: gaps, line starts, mode flips, biased extremes, rare resets
      for (int i = 0; i < 3000; i++) begin
         logic [7:0] x;
         int         sel;
         sel = int'($urandom_range(0, 9));
         x   = (sel == 0) ? 8'd0 : (sel == 1) ? 8'd255 : 8'($urandom);
         paso($urandom_range(0, 199) == 0,
              $urandom_range(0, 9) < 7,
              $urandom_range(0, 19) == 0,
              $urandom_range(0, 5) == 0,
              x);
      end
      ocioso(6);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
